// File: rtl/fp_add_seq_if.sv
// Bus bundle for fp_add_seq: batch control, byte-wide data memory port and
// the half-precision adder handshake. The master side is the sequencer.
interface fp_add_seq_if;
  // batch control
  logic        start;
  logic [3:0]  job_count;
  logic        busy;
  logic        done;
  logic        err;
  // data memory
  logic [7:0]  DataAddress;
  logic        ReadMem;
  logic        WriteMem;
  logic [7:0]  DataIn;
  logic [7:0]  DataOut;
  // adder core
  logic        add_start;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic        add_done;
  logic [15:0] add_sum;

  modport master (
    input  start, job_count, DataOut, add_done, add_sum,
    output busy, done, err, DataAddress, ReadMem, WriteMem, DataIn,
           add_start, add_a, add_b
  );

  modport slave (
    output start, job_count, DataOut, add_done, add_sum,
    input  busy, done, err, DataAddress, ReadMem, WriteMem, DataIn,
           add_start, add_a, add_b
  );
endinterface

// File: rtl/fp_add_seq.sv
// Memory-driven sequencer for the shared half-precision adder. Each job record
// is 6 bytes: A hi/lo, B hi/lo, sum hi/lo. Operands are fetched, the adder is
// launched, and the sum is written back beside its operands.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for start; done/err hold their last value
// S_READ   | byte counter 0..4: reads issued at 0..3, captured at 1..4
// S_LAUNCH | one-cycle add_start pulse, timeout timer loaded
// S_WAIT   | waiting for add_done; timer expiry aborts the batch
// S_WR_HI  | write sum[15:8] to record +4
// S_WR_LO  | write sum[7:0] to record +5, advance to next job
// S_DONE   | single cycle, done already set, returns to idle
module fp_add_seq #(
  parameter int BASE_ADDR  = 128,
  parameter int JOB_STRIDE = 6,
  parameter int TIMEOUT    = 255
) (
  input logic          clk,
  input logic          reset,
  fp_add_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_LAUNCH, S_WAIT, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  localparam logic [7:0] C_BASE     = 8'(BASE_ADDR);
  localparam logic [7:0] C_STRIDE   = 8'(JOB_STRIDE);
  // The timer is checked before decrementing, so loading TIMEOUT-1 gives
  // exactly TIMEOUT cycles in S_WAIT.
  localparam logic [7:0] C_TMR_LOAD = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic [3:0]  r_job;
  logic [3:0]  r_njobs;
  logic [7:0]  r_addr;
  logic [7:0]  r_tmr;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_sum;
  logic        r_done;
  logic        r_err;
  logic        w_accept;
  logic        w_timeout;
  logic        w_last;

  assign w_last        = ((r_job + 4'd1) == r_njobs);
  assign bus.busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.add_a     = r_a;
  assign bus.add_b     = r_b;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and Moore outputs for the memory and adder ports.
  always_comb begin
    w_next          = r_state;
    w_accept        = 1'b0;
    w_timeout       = 1'b0;
    bus.ReadMem     = 1'b0;
    bus.WriteMem    = 1'b0;
    bus.DataAddress = 8'd0;
    bus.DataIn      = 8'd0;
    bus.add_start   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = (bus.job_count == 4'd0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (r_cnt != 3'd4) begin
          bus.ReadMem     = 1'b1;
          bus.DataAddress = r_addr + {5'd0, r_cnt};
        end else begin
          w_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        bus.add_start = 1'b1;
        w_next        = S_WAIT;
      end
      S_WAIT: begin
        if (bus.add_done) begin
          w_next = S_WR_HI;
        end else if (r_tmr == 8'd0) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_WR_HI: begin
        bus.WriteMem    = 1'b1;
        bus.DataAddress = r_addr + 8'd4;
        bus.DataIn      = r_sum[15:8];
        w_next          = S_WR_LO;
      end
      S_WR_LO: begin
        bus.WriteMem    = 1'b1;
        bus.DataAddress = r_addr + 8'd5;
        bus.DataIn      = r_sum[7:0];
        w_next          = w_last ? S_DONE : S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Job bookkeeping, operand capture, timeout timer and sticky status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 3'd0;
      r_job   <= 4'd0;
      r_njobs <= 4'd0;
      r_addr  <= 8'd0;
      r_tmr   <= 8'd0;
      r_a     <= 16'd0;
      r_b     <= 16'd0;
      r_sum   <= 16'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_njobs <= bus.job_count;
            r_job   <= 4'd0;
            r_addr  <= C_BASE;
            r_cnt   <= 3'd0;
          end
        end
        S_READ: begin
          r_cnt <= r_cnt + 3'd1;
          case (r_cnt)
            3'd1:    r_a[15:8] <= bus.DataOut;
            3'd2:    r_a[7:0]  <= bus.DataOut;
            3'd3:    r_b[15:8] <= bus.DataOut;
            3'd4:    r_b[7:0]  <= bus.DataOut;
            default: ;
          endcase
        end
        S_LAUNCH: r_tmr <= C_TMR_LOAD;
        S_WAIT: begin
          if (bus.add_done)          r_sum <= bus.add_sum;
          else if (r_tmr != 8'd0)    r_tmr <= r_tmr - 8'd1;
        end
        S_WR_LO: begin
          r_job  <= r_job + 4'd1;
          r_addr <= r_addr + C_STRIDE;
          r_cnt  <= 3'd0;
        end
        default: ;
      endcase
      // Placed after the accept clear so a zero-job start still ends with done=1.
      if (w_next == S_DONE) r_done <= 1'b1;
      if (w_timeout)        r_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: byte memory and adder models per instance,
// hand-computed sums and cycle counts.
module tb_fp_add_seq;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_add_seq_if if0();
  fp_add_seq_if if1();

  fp_add_seq #(.BASE_ADDR(128), .JOB_STRIDE(6), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .bus(if0)
  );
  fp_add_seq #(.BASE_ADDR(252), .JOB_STRIDE(6), .TIMEOUT(255)) u_dut_w (
    .clk(clk), .reset(reset), .bus(if1)
  );

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  int          rd_cnt = 0, wr_cnt = 0, st_cnt = 0, both_cnt = 0;
  int          st_base = 0;
  int          lat_tab [16];
  logic [15:0] sum_tab [16];
  logic [31:0] ops [16];
  bit          ans_en = 1'b1;
  int          ad_cnt0 = 0, ad_cnt1 = 0;
  logic [15:0] ad_sum0 = 16'd0;
  logic [7:0]  rd_addr1 [$];
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [7:0]  ld_a = 8'd0, ld_d = 8'd0;
  int          n_checks = 0, n_fail = 0;

  assign if0.add_done = (ad_cnt0 == 1);
  assign if0.add_sum  = ad_sum0;
  assign if1.add_done = (ad_cnt1 == 1);
  assign if1.add_sum  = 16'h3E00;

  // memory + adder model for the base-128 instance
  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem0[ld_a] <= ld_d;
    if (if0.ReadMem) begin
      if0.DataOut <= mem0[if0.DataAddress];
      rd_cnt      <= rd_cnt + 1;
    end
    if (if0.WriteMem) begin
      mem0[if0.DataAddress] <= if0.DataIn;
      wr_cnt                <= wr_cnt + 1;
    end
    if (if0.ReadMem && if0.WriteMem) both_cnt <= both_cnt + 1;
    if (if0.add_start) begin
      ad_cnt0                  <= ans_en ? lat_tab[(st_cnt - st_base) & 15] : 0;
      ad_sum0                  <= sum_tab[(st_cnt - st_base) & 15];
      ops[(st_cnt - st_base) & 15] <= {if0.add_a, if0.add_b};
      st_cnt                   <= st_cnt + 1;
    end else if (ad_cnt0 > 0) begin
      ad_cnt0 <= ad_cnt0 - 1;
    end
  end

  // memory + fixed-latency adder model for the base-252 instance
  always @(posedge clk) begin
    if (ld_en && ld_sel) mem1[ld_a] <= ld_d;
    if (if1.ReadMem) begin
      if1.DataOut <= mem1[if1.DataAddress];
      rd_addr1.push_back(if1.DataAddress);
    end
    if (if1.WriteMem) mem1[if1.DataAddress] <= if1.DataIn;
    if (if1.ReadMem && if1.WriteMem) both_cnt <= both_cnt + 1;
    if (if1.add_start)   ad_cnt1 <= 2;
    else if (ad_cnt1 > 0) ad_cnt1 <= ad_cnt1 - 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_wr(input bit sel, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_sel = sel; ld_a = a; ld_d = d; ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Cycles counted so that the state right after the accepting edge is cycle 1.
  task automatic run_batch(input bit sel, input logic [3:0] n, input int limit,
                           input int poke_at, output int cycles);
    bit fin;
    @(negedge clk);
    if (sel) begin if1.start = 1'b1; if1.job_count = n; end
    else     begin if0.start = 1'b1; if0.job_count = n; end
    @(posedge clk);
    cycles = 1;
    fin    = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if0.start = 1'b0;
      if1.start = 1'b0;
      if (cycles == poke_at) begin
        if0.start     = 1'b1;
        if0.job_count = 4'hF;
      end
      if ((sel ? if1.done : if0.done) == 1'b1) begin
        fin = 1'b1;
      end else if (cycles >= limit) begin
        cycles = -1;
        fin    = 1'b1;
      end else begin
        @(posedge clk);
        cycles++;
      end
    end
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic put_job(input logic [7:0] a, input logic [15:0] opa, input logic [15:0] opb);
    mem_wr(1'b0, a,        opa[15:8]);
    mem_wr(1'b0, a + 8'd1, opa[7:0]);
    mem_wr(1'b0, a + 8'd2, opb[15:8]);
    mem_wr(1'b0, a + 8'd3, opb[7:0]);
    mem_wr(1'b0, a + 8'd4, 8'hAA);
    mem_wr(1'b0, a + 8'd5, 8'h55);
  endtask

  initial begin
    int cyc, rd0, wr0, st0;
    reset = 1'b0;
    if0.start = 1'b0; if0.job_count = 4'd0;
    if1.start = 1'b0; if1.job_count = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctl", {26'd0, if0.busy, if0.done, if0.err, if0.ReadMem, if0.WriteMem, if0.add_start}, 32'd0);
    chk("rst_addr_data", {16'd0, if0.DataAddress, if0.DataIn}, 32'd0);
    chk("rst_ops", {if0.add_a, if0.add_b}, 32'd0);
    reset = 1'b1;

    // zero-job batch: immediate done, no bus traffic
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = st_cnt;
    run_batch(1'b0, 4'd0, 10, 0, cyc);
    chk("zero_cycles", cyc, 1);
    chk("zero_traffic", (rd_cnt - rd0) + (wr_cnt - wr0) + (st_cnt - st0), 0);

    // single job 1.0 + 1.0
    put_job(8'd128, 16'h3C00, 16'h3C00);
    st_base = st_cnt; lat_tab[0] = 3; sum_tab[0] = 16'h4000;
    rd0 = rd_cnt; wr0 = wr_cnt;
    run_batch(1'b0, 4'd1, 100, 0, cyc);
    chk("one_cycles", cyc, 12);
    chk("one_sum", {16'd0, mem0[132], mem0[133]}, 32'h4000);
    chk("one_ops", ops[0], 32'h3C003C00);
    chk("one_traffic", {(rd_cnt - rd0), (wr_cnt - wr0)} , {32'd4, 32'd2});
    chk("one_err", if0.err, 1'b0);

    // three jobs with varied latency and a start poked mid-batch
    put_job(8'd128, 16'h4000, 16'h3800);
    put_job(8'd134, 16'h3C00, 16'h3C00);
    put_job(8'd140, 16'h0000, 16'h0000);
    st_base = st_cnt;
    lat_tab[0] = 1; sum_tab[0] = 16'h4100;
    lat_tab[1] = 5; sum_tab[1] = 16'h4000;
    lat_tab[2] = 2; sum_tab[2] = 16'h0000;
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = st_cnt;
    run_batch(1'b0, 4'd3, 200, 10, cyc);
    chk("three_cycles", cyc, 33);
    chk("three_sum0", {16'd0, mem0[132], mem0[133]}, 32'h4100);
    chk("three_sum1", {16'd0, mem0[138], mem0[139]}, 32'h4000);
    chk("three_sum2", {16'd0, mem0[144], mem0[145]}, 32'h0000);
    chk("three_ops0", ops[0], 32'h40003800);
    chk("three_ops2", ops[2], 32'h00000000);
    repeat (3) @(negedge clk);
    chk("three_starts", st_cnt - st0, 3);
    chk("three_reads", rd_cnt - rd0, 12);
    chk("three_writes", wr_cnt - wr0, 6);
    chk("three_idle", if0.busy, 1'b0);

    // address wrap on the base-252 instance: 1.0 + 0.5
    mem_wr(1'b1, 8'd252, 8'h3C); mem_wr(1'b1, 8'd253, 8'h00);
    mem_wr(1'b1, 8'd254, 8'h38); mem_wr(1'b1, 8'd255, 8'h00);
    mem_wr(1'b1, 8'd0, 8'hAA);   mem_wr(1'b1, 8'd1, 8'h55);
    run_batch(1'b1, 4'd1, 100, 0, cyc);
    chk("wrap_cycles", cyc, 11);
    chk("wrap_sum", {16'd0, mem1[0], mem1[1]}, 32'h3E00);
    chk("wrap_nreads", rd_addr1.size(), 4);
    if (rd_addr1.size() == 4)
      chk("wrap_raddr", {rd_addr1[0], rd_addr1[1], rd_addr1[2], rd_addr1[3]}, 32'hFCFDFEFF);

    // adder never answers: timeout aborts the batch
    ans_en = 1'b0;
    st_base = st_cnt;
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = st_cnt;
    run_batch(1'b0, 4'd2, 400, 0, cyc);
    chk("tmo_cycles", cyc, 262);
    chk("tmo_err_done", {30'd0, if0.err, if0.done}, 32'd3);
    repeat (3) @(negedge clk);
    chk("tmo_no_write", wr_cnt - wr0, 0);
    chk("tmo_skip", {(rd_cnt - rd0), (st_cnt - st0)}, {32'd4, 32'd1});
    ans_en = 1'b1;
    st_base = st_cnt; lat_tab[0] = 1; sum_tab[0] = 16'h4100;
    run_batch(1'b0, 4'd1, 100, 0, cyc);
    chk("tmo_recover_cycles", cyc, 10);
    chk("tmo_err_cleared", if0.err, 1'b0);

    // reset asserted during the second job's WAIT
    st_base = st_cnt; wr0 = wr_cnt;
    lat_tab[0] = 1; lat_tab[1] = 20; lat_tab[2] = 1;
    @(negedge clk);
    if0.start = 1'b1; if0.job_count = 4'd3;
    @(posedge clk);
    #1 if0.start = 1'b0;
    for (int i = 0; i < 200 && (st_cnt - st_base) < 2; i++) @(posedge clk);
    chk("mid_launches", st_cnt - st_base, 2);
    repeat (3) @(posedge clk);
    #3;
    chk("mid_pre_ops", {if0.add_a, if0.add_b}, 32'h3C003C00);
    chk("mid_pre_busy", if0.busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_ctl", {26'd0, if0.busy, if0.done, if0.err, if0.ReadMem, if0.WriteMem, if0.add_start}, 32'd0);
    chk("mid_rst_bus", {if0.DataAddress, if0.DataIn, 16'd0}, 32'd0);
    chk("mid_rst_ops", {if0.add_a, if0.add_b}, 32'd0);
    chk("mid_writes", wr_cnt - wr0, 2);
    @(negedge clk);
    reset = 1'b1;
    mem_wr(1'b0, 8'd132, 8'h00); mem_wr(1'b0, 8'd133, 8'h00);
    st_base = st_cnt; lat_tab[0] = 4; sum_tab[0] = 16'h4100;
    run_batch(1'b0, 4'd1, 100, 0, cyc);
    chk("post_rst_cycles", cyc, 13);
    chk("post_rst_sum", {16'd0, mem0[132], mem0[133]}, 32'h4100);

    chk("rd_wr_exclusive", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
